// File: rtl/if_stage_pkg.sv
// Shared MIPS pipeline definitions: default widths, reset PC and the nop
// encoding used by the fetch stage and the decode stage.
package if_stage_pkg;

  localparam int DEF_PC_WIDTH      = 6;
  localparam int DEF_REG_DIR_WIDTH = 3;
  localparam int DEF_RESET_PC      = 0;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Bit positions of the rs and rt register fields in an R/I-type word.
  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory read bus.
// The fetch stage drives the word address.
// The memory answers combinationally in the same cycle.
interface if_stage_if #(
  parameter int PC_WIDTH = if_stage_pkg::DEF_PC_WIDTH
);

  logic [PC_WIDTH-1:0] imem_addr;
  logic [31:0]         imem_data;

  modport master (
    output imem_addr,
    input  imem_data
  );

  modport slave (
    input  imem_addr,
    output imem_data
  );

endinterface

// File: rtl/if_stage_ifid.sv
// IF/ID pipeline register.
// Priority of the controls is: reset, then hold (en low), then squash (clr),
// then load.
// clr is ignored while en is low, so a squash requested on stale decode
// operands during a stall never takes effect.
module ifid_reg
  import if_stage_pkg::*;
#(
  parameter int PC_WIDTH = DEF_PC_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                clr,
  input  logic [31:0]         instr_d,
  input  logic [PC_WIDTH-1:0] pc_next_d,
  output logic [31:0]         instr_q,
  output logic [PC_WIDTH-1:0] pc_next_q,
  output logic                valid_q
);

  // Update the IF/ID fields: reset, hold, squash to nop, or capture the fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q   <= NOP_INSTR;
      pc_next_q <= '0;
      valid_q   <= 1'b0;
    end else if (en) begin
      if (clr) begin
        instr_q   <= NOP_INSTR;
        pc_next_q <= '0;
        valid_q   <= 1'b0;
      end else begin
        instr_q   <= instr_d;
        pc_next_q <= pc_next_d;
        valid_q   <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage of the pipelined MIPS.
// The stage holds the PC register, the +1 incrementer and the next-PC mux.
// It drives the instruction-memory address straight from the PC.
// It feeds the IF/ID register, which decode reads from.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int PC_WIDTH      = DEF_PC_WIDTH,
  parameter int REG_DIR_WIDTH = DEF_REG_DIR_WIDTH,
  parameter int RESET_PC      = DEF_RESET_PC
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     Stall,
  input  logic                     Branch,
  input  logic                     Iguales,
  input  logic                     IF_Flush,
  input  logic [PC_WIDTH-1:0]      ALUR,
  if_stage_if.master               imem,
  output logic [PC_WIDTH-1:0]      PC,
  output logic [31:0]              Instruction,
  output logic [PC_WIDTH-1:0]      PCNext,
  output logic                     IFID_Valid,
  output logic [REG_DIR_WIDTH-1:0] IFID_RegisterRs,
  output logic [REG_DIR_WIDTH-1:0] IFID_RegisterRt
);

  localparam logic [PC_WIDTH-1:0] RESET_PC_V = PC_WIDTH'(RESET_PC);
  localparam logic [PC_WIDTH-1:0] PC_ONE     = PC_WIDTH'(1);

  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] seq;
  logic [PC_WIDTH-1:0] pc_d;
  logic                taken;

  // A branch only redirects when the stage is not stalled.
  // During a stall the comparator result comes from stale operands.
  assign taken = Branch & Iguales & ~Stall;

  // The incrementer wraps naturally at 2^PC_WIDTH.
  assign seq = pc_q + PC_ONE;

  // Next-PC mux: hold on stall, otherwise the branch target or the next sequential address.
  always_comb begin
    pc_d = seq;
    if (Stall) begin
      pc_d = pc_q;
    end else if (taken) begin
      pc_d = ALUR;
    end
  end

  // PC register; reset wins over every other control.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC_V;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign PC             = pc_q;
  assign imem.imem_addr = pc_q;

  ifid_reg #(
    .PC_WIDTH (PC_WIDTH)
  ) u_ifid (
    .clk       (clk),
    .rst       (rst),
    .en        (~Stall),
    .clr       (IF_Flush),
    .instr_d   (imem.imem_data),
    .pc_next_d (seq),
    .instr_q   (Instruction),
    .pc_next_q (PCNext),
    .valid_q   (IFID_Valid)
  );

  assign IFID_RegisterRs = Instruction[REG_DIR_WIDTH-1+RS_LSB:RS_LSB];
  assign IFID_RegisterRt = Instruction[REG_DIR_WIDTH-1+RT_LSB:RT_LSB];

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage.
// Inputs change and outputs are checked 1 time unit after each rising edge.
module tb_if_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       Stall;
  logic       Branch;
  logic       Iguales;
  logic       IF_Flush;
  logic [5:0] ALUR;
  logic [5:0] PC;
  logic [31:0] Instruction;
  logic [5:0] PCNext;
  logic       IFID_Valid;
  logic [2:0] IFID_RegisterRs;
  logic [2:0] IFID_RegisterRt;

  logic [31:0] mem [64];

  int total  = 0;
  int passed = 0;

  if_stage_if #(.PC_WIDTH(6)) imem_bus ();

  assign imem_bus.imem_data = mem[imem_bus.imem_addr];

  if_stage #(
    .PC_WIDTH      (6),
    .REG_DIR_WIDTH (3),
    .RESET_PC      (0)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .Stall           (Stall),
    .Branch          (Branch),
    .Iguales         (Iguales),
    .IF_Flush        (IF_Flush),
    .ALUR            (ALUR),
    .imem            (imem_bus.master),
    .PC              (PC),
    .Instruction     (Instruction),
    .PCNext          (PCNext),
    .IFID_Valid      (IFID_Valid),
    .IFID_RegisterRs (IFID_RegisterRs),
    .IFID_RegisterRt (IFID_RegisterRt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic check_state(input string tag, input logic [5:0] pc_e,
                             input logic [31:0] instr_e, input logic [5:0] pcn_e,
                             input logic valid_e);
    logic [31:0] ie;
    ie = instr_e;
    chk({tag, ".PC"},        32'(PC),              32'(pc_e));
    chk({tag, ".imem_addr"}, 32'(imem_bus.imem_addr), 32'(pc_e));
    chk({tag, ".Instr"},     Instruction,          ie);
    chk({tag, ".PCNext"},    32'(PCNext),          32'(pcn_e));
    chk({tag, ".Valid"},     32'(IFID_Valid),      32'(valid_e));
    chk({tag, ".Rs"},        32'(IFID_RegisterRs), 32'(ie[23:21]));
    chk({tag, ".Rt"},        32'(IFID_RegisterRt), 32'(ie[18:16]));
  endtask

  task automatic set_ctl(input logic s, input logic b, input logic q,
                         input logic f, input logic [5:0] a);
    Stall = s; Branch = b; Iguales = q; IF_Flush = f; ALUR = a;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = 32'h2000_0000 | (32'(i) << 21) | (32'((i * 5) % 8) << 16) | 32'(i + 1);
    end
    mem[0] = 32'h8C01_0004;

    // Reset for two cycles
    rst = 1'b1;
    set_ctl(0, 0, 0, 0, 6'd0);
    tick();
    tick();
    check_state("reset", 6'd0, 32'h0, 6'd0, 1'b0);

    // Release: first fetch from address 0
    rst = 1'b0;
    tick();
    check_state("first_fetch", 6'd1, 32'h8C01_0004, 6'd1, 1'b1);
    chk("first_fetch.Rt_const", 32'(IFID_RegisterRt), 32'd1);

    // Run sequentially up to PC=5
    tick(); tick(); tick(); tick();
    check_state("seq_pc5", 6'd5, mem[4], 6'd5, 1'b1);

    // Stall for three cycles
    set_ctl(1, 0, 0, 0, 6'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_state("stall_hold", 6'd5, mem[4], 6'd5, 1'b1);
    end
    set_ctl(0, 0, 0, 0, 6'd0);
    tick();
    check_state("stall_resume", 6'd6, mem[5], 6'd6, 1'b1);

    // Taken branch with flush at PC=7
    tick();
    set_ctl(0, 1, 1, 1, 6'd20);
    tick();
    check_state("branch_flush", 6'd20, 32'h0, 6'd0, 1'b0);
    set_ctl(0, 0, 0, 0, 6'd0);
    tick();
    check_state("branch_target", 6'd21, mem[20], 6'd21, 1'b1);

    // Branch and flush while stalled are held off until the stall drops
    set_ctl(1, 1, 1, 1, 6'd20);
    tick();
    check_state("stall_branch1", 6'd21, mem[20], 6'd21, 1'b1);
    tick();
    check_state("stall_branch2", 6'd21, mem[20], 6'd21, 1'b1);
    set_ctl(0, 1, 1, 1, 6'd20);
    tick();
    check_state("stall_branch_go", 6'd20, 32'h0, 6'd0, 1'b0);

    // Taken without flush: PC redirects, IF/ID keeps the fetched word
    set_ctl(0, 0, 0, 0, 6'd0);
    tick();
    check_state("pre_noflush", 6'd21, mem[20], 6'd21, 1'b1);
    set_ctl(0, 1, 1, 0, 6'd30);
    tick();
    check_state("taken_noflush", 6'd30, mem[21], 6'd22, 1'b1);

    // Self-loop: ALUR equals the current PC
    set_ctl(0, 1, 1, 0, 6'd30);
    tick();
    check_state("self_loop", 6'd30, mem[30], 6'd31, 1'b1);
    set_ctl(0, 0, 0, 0, 6'd0);
    tick();
    check_state("after_loop", 6'd31, mem[30], 6'd31, 1'b1);

    // Branch with operands unequal: not taken
    set_ctl(0, 1, 0, 0, 6'd10);
    tick();
    check_state("not_taken", 6'd32, mem[31], 6'd32, 1'b1);

    // Jump to 63, then wrap around to 0
    set_ctl(0, 1, 1, 0, 6'd63);
    tick();
    check_state("to_63", 6'd63, mem[32], 6'd33, 1'b1);
    set_ctl(0, 0, 0, 0, 6'd0);
    tick();
    check_state("wrap", 6'd0, mem[63], 6'd0, 1'b1);

    // Flush on its own squashes IF/ID but PC advances
    set_ctl(0, 0, 0, 1, 6'd0);
    tick();
    check_state("flush_only", 6'd1, 32'h0, 6'd0, 1'b0);

    // Reset in the same cycle as a taken branch
    set_ctl(0, 0, 0, 0, 6'd0);
    tick();
    check_state("pre_rst_branch", 6'd2, mem[1], 6'd2, 1'b1);
    rst = 1'b1;
    set_ctl(0, 1, 1, 1, 6'd20);
    tick();
    check_state("rst_over_branch", 6'd0, 32'h0, 6'd0, 1'b0);

    // Reset in the middle of a stall
    rst = 1'b0;
    set_ctl(0, 0, 0, 0, 6'd0);
    tick();
    set_ctl(1, 0, 0, 0, 6'd0);
    tick();
    check_state("pre_rst_stall", 6'd1, 32'h8C01_0004, 6'd1, 1'b1);
    rst = 1'b1;
    tick();
    check_state("rst_over_stall", 6'd0, 32'h0, 6'd0, 1'b0);
    rst = 1'b0;
    set_ctl(0, 0, 0, 0, 6'd0);
    tick();
    check_state("refetch_after_rst", 6'd1, 32'h8C01_0004, 6'd1, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL have parameter PC_WIDTH, default 6, meaning the word-address width of PC, PCNext and ALUR.
REQ-002 The block SHALL have parameter REG_DIR_WIDTH, default 3, meaning the register-address width of IFID_RegisterRs/Rt.
REQ-003 The block SHALL have parameter RESET_PC, default 0, meaning the PC value loaded on reset.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, the reset; synchronous and active-high.
REQ-006 The block SHALL have port Stall, input, 1, from the hazard unit; holds PC and the IF/ID register.
REQ-007 The block SHALL have port Branch, input, 1, from the ID-stage control; current ID instruction is a beq.
REQ-008 The block SHALL have port Iguales, input, 1, from the ID-stage comparator; forwarded operands equal.
REQ-009 The block SHALL have port IF_Flush, input, 1, from the ID-stage control; squash the instruction being fetched.
REQ-010 The block SHALL have port ALUR, input, PC_WIDTH, the branch target from the ID stage.
REQ-011 The block SHALL have port imem_addr, output, PC_WIDTH, the instruction-memory word address, equal to PC.
REQ-012 The block SHALL have port imem_data, input, 32, the combinational instruction-memory read data.
REQ-013 The block SHALL have port PC, output, PC_WIDTH, the current fetch address.
REQ-014 The block SHALL have port Instruction, output, 32, the IF/ID instruction register.
REQ-015 The block SHALL have port PCNext, output, PC_WIDTH, the IF/ID copy of fetch PC + 1.
REQ-016 The block SHALL have port IFID_Valid, output, 1, set when IF/ID holds a real, unsquashed instruction.
REQ-017 The block SHALL have ports IFID_RegisterRs and IFID_RegisterRt, output, REG_DIR_WIDTH each, equal to Instruction[REG_DIR_WIDTH-1+21:21] and Instruction[REG_DIR_WIDTH-1+16:16] respectively.

Function
REQ-018 The block SHALL compute seq = PC + 1 modulo 2^PC_WIDTH, so PC = all-ones wraps seq to 0.
REQ-019 The block SHALL define Taken = Branch & Iguales & ~Stall.
REQ-020 Each cycle, the PC update SHALL follow this priority: rst gives RESET_PC; else Stall holds PC; else Taken loads ALUR; else PC loads seq.
REQ-021 Each cycle, the IF/ID update SHALL follow this priority: rst clears it; else Stall holds all IF/ID fields; else IF_Flush loads Instruction=0 (nop), PCNext=0, IFID_Valid=0; else it loads Instruction=imem_data, PCNext=seq, IFID_Valid=1.
REQ-022 IF_Flush with Stall=1 SHALL be ignored, because the ID operands are stale during a stall.
REQ-023 A redirect SHALL have one-cycle latency: Taken in cycle n gives PC=ALUR in n+1 and Instruction=imem_data[ALUR] in n+2.
REQ-024 Taken=1 with IF_Flush=0 SHALL still redirect PC and SHALL NOT squash IF/ID; the ID-stage control is responsible for asserting both.
REQ-025 ALUR equal to the current PC (self-loop) SHALL be legal and SHALL refetch the same address.
REQ-026 imem_addr SHALL be a wire copy of PC with zero latency.
REQ-027 The block SHALL have no further internal state.

Reset
REQ-028 A reset edge SHALL give PC=RESET_PC, Instruction=0, PCNext=0, IFID_Valid=0, and therefore IFID_RegisterRs=IFID_RegisterRt=0.
REQ-029 rst SHALL override Stall, Taken and IF_Flush in the same cycle, including rst asserted mid-stall or mid-redirect.
REQ-030 The first fetch after reset release SHALL be from RESET_PC.

Structure
REQ-031 PC_WIDTH, REG_DIR_WIDTH, NOP_INSTR (32'h0) and RESET_PC defaults SHALL live in the shared MIPS package used by the ID stage.
REQ-032 The IF/ID register SHALL be one sub-module, ifid_reg, with ports clk, rst, en (~Stall), clr (IF_Flush), and the d/q fields.
REQ-033 PC register, incrementer and next-PC mux SHALL live in if_stage.

Verification
REQ-034 rst=1 for 2 cycles, then release with imem returning 32'h8C010004 at address 0: PC goes 0 then 1; Instruction=32'h8C010004, PCNext=1, IFID_Valid=1, Rs=0, Rt=1.
REQ-035 With PC=5, assert Stall for 3 cycles: PC stays 5, IF/ID unchanged for 3 cycles, and fetch resumes at 6.
REQ-036 With PC=7, apply Branch=Iguales=IF_Flush=1 and ALUR=20: next cycle PC=20, Instruction=0, IFID_Valid=0; following cycle Instruction=imem_data[20].
REQ-037 With Stall=1 together with Branch=Iguales=IF_Flush=1 and ALUR=20: PC and IF/ID hold; the redirect occurs only once Stall drops.
REQ-038 With PC=63 and no branch: next PC=0 and PCNext=0.
REQ-039 With rst=1 in the same cycle as Taken and ALUR=20: PC=0 and IFID_Valid=0.
